// File: rtl/mmio_timer_pwm.sv
// mmio_timer_pwm: memory-mapped PWM / timer peripheral decoded at 0xFFFFFF00-0xFFFFFFFF.
// Provides NUM_PWM PWM channels sharing one period, free-running MICROS/MILLIS
// counters, and a registered, funct3-formatted read port with one-cycle latency.
// Optional feature macro: TIMER_IRQ_EN adds IRQ_CSR (0xE8), MILLIS_CMP (0xEC)
// and the millisecond compare interrupt. Without it, irq is tied low.
module mmio_timer_pwm #(
    parameter int CLK_HZ   = 12_000_000,
    parameter int NUM_PWM  = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write_mem,
    input  logic [2:0]          funct3,
    input  logic [31:0]         write_address,
    input  logic [31:0]         write_data,
    input  logic [31:0]         read_address,
    output logic [31:0]         read_data,
    output logic [NUM_PWM-1:0]  pwm_out,
    output logic                irq
);

    localparam int DIV_US = CLK_HZ / 1_000_000;
    localparam int DIV_MS = CLK_HZ / 1000;
    localparam int US_W   = $clog2(DIV_US + 1);
    localparam int MS_W   = $clog2(DIV_MS + 1);
    localparam logic [US_W-1:0]     US_LAST    = US_W'(DIV_US - 1);
    localparam logic [MS_W-1:0]     MS_LAST    = MS_W'(DIV_MS - 1);
    localparam logic [PWM_BITS-1:0] PERIOD_RST = {PWM_BITS{1'b1}};
    localparam logic [5:0]          IDX_PERIOD = 6'd60;
    localparam logic [5:0]          IDX_MICROS = 6'd61;
    localparam logic [5:0]          IDX_MILLIS = 6'd62;
`ifdef TIMER_IRQ_EN
    localparam logic [5:0]          IDX_CSR    = 6'd58;
    localparam logic [5:0]          IDX_CMP    = 6'd59;
`endif

    // Merge a right-aligned store into the addressed byte lanes of old_v.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old_v,
        input logic [31:0] wdata,
        input logic [1:0]  lane,
        input logic [2:0]  f3
    );
        logic [31:0] v;
        v = old_v;
        if (f3[1]) begin
            v = wdata;
        end else if (f3[0]) begin
            if (lane[1]) begin
                v[31:16] = wdata[15:0];
            end else begin
                v[15:0] = wdata[15:0];
            end
        end else begin
            case (lane)
                2'd0:    v[7:0]   = wdata[7:0];
                2'd1:    v[15:8]  = wdata[7:0];
                2'd2:    v[23:16] = wdata[7:0];
                default: v[31:24] = wdata[7:0];
            endcase
        end
        return v;
    endfunction

    // Select and extend the load lanes of a 32-bit register value.
    function automatic logic [31:0] format_load(
        input logic [31:0] val,
        input logic [1:0]  lane,
        input logic [2:0]  f3
    );
        logic [31:0] r;
        logic [15:0] h;
        logic [7:0]  b;
        h = 16'h0000;
        b = 8'h00;
        if (f3[1]) begin
            r = val;
        end else if (f3[0]) begin
            if (lane[1]) begin
                h = val[31:16];
            end else begin
                h = val[15:0];
            end
            if (f3[2]) begin
                r = {16'h0000, h};
            end else begin
                r = {{16{h[15]}}, h};
            end
        end else begin
            case (lane)
                2'd0:    b = val[7:0];
                2'd1:    b = val[15:8];
                2'd2:    b = val[23:16];
                default: b = val[31:24];
            endcase
            if (f3[2]) begin
                r = {24'h000000, b};
            end else begin
                r = {{24{b[7]}}, b};
            end
        end
        return r;
    endfunction

`ifdef TIMER_IRQ_EN
    // True when the store of this cycle covers byte lane 0.
    function automatic logic lane0_written(input logic [1:0] lane, input logic [2:0] f3);
        logic w;
        if (f3[1]) begin
            w = 1'b1;
        end else if (f3[0]) begin
            w = ~lane[1];
        end else begin
            w = (lane == 2'd0);
        end
        return w;
    endfunction
`endif

    logic [PWM_BITS-1:0] duty_shadow_q [NUM_PWM];
    logic [PWM_BITS-1:0] duty_shadow_d [NUM_PWM];
    logic [PWM_BITS-1:0] duty_active_q [NUM_PWM];
    logic [PWM_BITS-1:0] duty_active_d [NUM_PWM];
    logic [PWM_BITS-1:0] period_shadow_q, period_shadow_d;
    logic [PWM_BITS-1:0] period_active_q, period_active_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [NUM_PWM-1:0]  pwm_q, pwm_d;
    logic [US_W-1:0]     us_div_q, us_div_d;
    logic [MS_W-1:0]     ms_div_q, ms_div_d;
    logic [31:0]         micros_q, micros_d;
    logic [31:0]         millis_q, millis_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         rd_val_s;
    logic                us_tick_s, ms_tick_s, wrap_s;
    logic                wr_hit_s, rd_hit_s;
    logic [5:0]          wr_idx_s, rd_idx_s;

    assign wr_hit_s = write_mem && (write_address[31:8] == 24'hFFFFFF);
    assign rd_hit_s = (read_address[31:8] == 24'hFFFFFF);
    assign wr_idx_s = write_address[7:2];
    assign rd_idx_s = read_address[7:2];

    // Software writes into the DUTY and PERIOD shadow registers.
    always_comb begin
        duty_shadow_d   = duty_shadow_q;
        period_shadow_d = period_shadow_q;
        if (wr_hit_s) begin
            if (wr_idx_s == IDX_PERIOD) begin
                period_shadow_d = PWM_BITS'(merge_store(32'(period_shadow_q), write_data,
                                                        write_address[1:0], funct3));
            end else begin
                for (int k = 0; k < NUM_PWM; k++) begin
                    if (wr_idx_s == 6'(k)) begin
                        duty_shadow_d[k] = PWM_BITS'(merge_store(32'(duty_shadow_q[k]), write_data,
                                                                 write_address[1:0], funct3));
                    end else begin
                        duty_shadow_d[k] = duty_shadow_q[k];
                    end
                end
            end
        end else begin
            period_shadow_d = period_shadow_q;
        end
    end

    // PWM counter; shadows load into the active set only when the counter wraps.
    always_comb begin
        wrap_s          = (cnt_q == period_active_q);
        duty_active_d   = duty_active_q;
        period_active_d = period_active_q;
        if (wrap_s) begin
            cnt_d           = {PWM_BITS{1'b0}};
            duty_active_d   = duty_shadow_q;
            period_active_d = period_shadow_q;
        end else begin
            cnt_d = cnt_q + PWM_BITS'(1);
        end
        for (int k = 0; k < NUM_PWM; k++) begin
            pwm_d[k] = (cnt_d < duty_active_d[k]);
        end
    end

    // Microsecond and millisecond dividers with their free-running counters.
    always_comb begin
        us_tick_s = (us_div_q == US_LAST);
        ms_tick_s = (ms_div_q == MS_LAST);
        if (us_tick_s) begin
            us_div_d = {US_W{1'b0}};
            micros_d = micros_q + 32'd1;
        end else begin
            us_div_d = us_div_q + US_W'(1);
            micros_d = micros_q;
        end
        if (ms_tick_s) begin
            ms_div_d = {MS_W{1'b0}};
            millis_d = millis_q + 32'd1;
        end else begin
            ms_div_d = ms_div_q + MS_W'(1);
            millis_d = millis_q;
        end
    end

`ifdef TIMER_IRQ_EN
    logic        pending_q, pending_d;
    logic        enable_q, enable_d;
    logic        irq_q, irq_d;
    logic [31:0] cmp_q, cmp_d;
    logic        csr_wr_s, cmp_match_s;

    // Compare match, IRQ_CSR/MILLIS_CMP writes; a match beats a same-edge clear.
    always_comb begin
        cmp_match_s = ms_tick_s && ((millis_q + 32'd1) == cmp_q);
        csr_wr_s    = wr_hit_s && (wr_idx_s == IDX_CSR) && lane0_written(write_address[1:0], funct3);
        if (wr_hit_s && (wr_idx_s == IDX_CMP)) begin
            cmp_d = merge_store(cmp_q, write_data, write_address[1:0], funct3);
        end else begin
            cmp_d = cmp_q;
        end
        if (csr_wr_s) begin
            enable_d = write_data[1];
        end else begin
            enable_d = enable_q;
        end
        if (cmp_match_s) begin
            pending_d = 1'b1;
        end else if (csr_wr_s && write_data[0]) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        irq_d = pending_d & enable_d;
    end

    // Compare state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            enable_q  <= 1'b0;
            irq_q     <= 1'b0;
            cmp_q     <= 32'hFFFF_FFFF;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            irq_q     <= irq_d;
            cmp_q     <= cmp_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read mux over the current (pre-write) register values, zero-extended.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        if (rd_hit_s) begin
            case (rd_idx_s)
                IDX_PERIOD: rd_val_s = 32'(period_shadow_q);
                IDX_MICROS: rd_val_s = micros_q;
                IDX_MILLIS: rd_val_s = millis_q;
`ifdef TIMER_IRQ_EN
                IDX_CSR:    rd_val_s = {30'h0, enable_q, pending_q};
                IDX_CMP:    rd_val_s = cmp_q;
`endif
                default: begin
                    for (int k = 0; k < NUM_PWM; k++) begin
                        if (rd_idx_s == 6'(k)) begin
                            rd_val_s = 32'(duty_shadow_q[k]);
                        end else begin
                            rd_val_s = rd_val_s;
                        end
                    end
                end
            endcase
        end else begin
            rd_val_s = 32'h0000_0000;
        end
        rdata_d = format_load(rd_val_s, read_address[1:0], funct3);
    end

    // Main state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PWM; k++) begin
                duty_shadow_q[k] <= {PWM_BITS{1'b0}};
                duty_active_q[k] <= {PWM_BITS{1'b0}};
            end
            period_shadow_q <= PERIOD_RST;
            period_active_q <= PERIOD_RST;
            cnt_q           <= {PWM_BITS{1'b0}};
            pwm_q           <= {NUM_PWM{1'b0}};
            us_div_q        <= {US_W{1'b0}};
            ms_div_q        <= {MS_W{1'b0}};
            micros_q        <= 32'h0000_0000;
            millis_q        <= 32'h0000_0000;
            rdata_q         <= 32'h0000_0000;
        end else begin
            duty_shadow_q   <= duty_shadow_d;
            duty_active_q   <= duty_active_d;
            period_shadow_q <= period_shadow_d;
            period_active_q <= period_active_d;
            cnt_q           <= cnt_d;
            pwm_q           <= pwm_d;
            us_div_q        <= us_div_d;
            ms_div_q        <= ms_div_d;
            micros_q        <= micros_d;
            millis_q        <= millis_d;
            rdata_q         <= rdata_d;
        end
    end

    assign read_data = rdata_q;
    assign pwm_out   = pwm_q;

endmodule
